// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit and its helpers.
// Contents:
//   OP_LOAD / OP_STORE      major opcodes the LSU reacts to
//   F3_B .. F3_HU           access size/sign encodings in FUNCT3
//   lsu_state_t             LSU control FSM states
//   access_ok()             legality + alignment check for one access
//   store_strobe()          byte-enable pattern for a store
//   store_lanes()           store data replicated across byte lanes
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE,
    FAULT_ST
  } lsu_state_t;

  // Returns 1 when the size field is legal for the access kind and the
  // address offset is naturally aligned for that size. Unsigned sizes
  // only exist for loads.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for a store of the given size at byte offset off.
  function automatic logic [3:0] store_strobe(input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [3:0] strb;
    strb = 4'b0000;
    case (f3)
      F3_B:    strb = 4'b0001 << off;
      F3_H:    strb = 4'b0011 << off;
      F3_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Replicate the low byte/half across the word so that whichever lane the
  // strobes select already carries the right data.
  function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                              input logic [31:0] data);
    logic [31:0] lanes;
    lanes = data;
    case (f3)
      F3_B:    lanes = {4{data[7:0]}};
      F3_H:    lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// ---------------------------------------------------------------------------
// load_align_ext
// Pure combinational load formatter: picks the addressed byte or halfword
// out of a memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata    in  32  raw memory word
//   off      in   2  byte offset of the access within the word
//   funct3   in   3  access size/sign field
//   ext_data out 32  aligned, extended load value
// ---------------------------------------------------------------------------
module load_align_ext
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select: halfwords are always naturally aligned, so only off[1]
  // matters for them.
  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension according to the size/sign field; full words pass through.
  always_comb begin
    ext_data = rdata;
    case (funct3)
      F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ext_data = {24'h000000, byte_sel};
      F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ext_data = {16'h0000, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Takes a load/store from execute, runs the data-memory request/grant/
// response handshake and returns the extended load word. Stores get byte
// strobes and lane-replicated data. The pipeline is held while an access
// is in flight.
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in WAIT_RESP without read data (1..255)
// Ports:
//   CLK, RST_N               clock, async active-low reset
//   EX_VALID, OPCODE, FUNCT3 instruction from execute
//   ADDR, STORE_DATA         effective address and store value
//   MEM_REQ/WE/ADDR/WSTRB/WDATA  request side of the memory port
//   MEM_GNT/RVALID/RDATA     grant and response side of the memory port
//   MEM_LOAD                 registered, extended load result
//   LSU_DONE, LSU_FAULT      completion pulse, fault pulse (with DONE)
//   LSU_STALL                combinational pipeline hold
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EX_VALID,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] STORE_DATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_WSTRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] MEM_LOAD,
  output logic        LSU_DONE,
  output logic        LSU_STALL,
  output logic        LSU_FAULT
);

  // The counter starts at 0 on the first WAIT_RESP cycle, so the last
  // allowed cycle is reached when it equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  lsu_state_t  state_next;

  logic        is_mem_op;
  logic        is_store_in;
  logic        accept;
  logic        legal;
  logic        capture;

  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [7:0]  count;
  logic [31:0] load_word;

  assign is_mem_op   = (OPCODE == OP_LOAD) || (OPCODE == OP_STORE);
  assign is_store_in = (OPCODE == OP_STORE);
  assign accept      = (state == IDLE) && EX_VALID && is_mem_op;
  assign legal       = access_ok(is_store_in, FUNCT3, ADDR[1:0]);

  // Read data is taken either together with the grant or later in
  // WAIT_RESP; RVALID anywhere else is stray and ignored.
  assign capture = (!is_store_q && MEM_RVALID) &&
                   (((state == REQ) && MEM_GNT) || (state == WAIT_RESP));

  load_align_ext u_align (
    .rdata    (MEM_RDATA),
    .off      (off_q),
    .funct3   (funct3_q),
    .ext_data (load_word)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. RVALID wins over the timeout on the final cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = legal ? REQ : FAULT_ST;
        end
      end
      REQ: begin
        if (MEM_GNT) begin
          if (is_store_q || MEM_RVALID) begin
            state_next = DONE;
          end else begin
            state_next = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (MEM_RVALID) begin
          state_next = DONE;
        end else if (count == TIMEOUT_LAST) begin
          state_next = FAULT_ST;
        end
      end
      DONE:     state_next = IDLE;
      FAULT_ST: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output decode. Stall drops in DONE/FAULT_ST so the pipeline advances
  // on the completion cycle.
  always_comb begin
    MEM_REQ   = 1'b0;
    LSU_DONE  = 1'b0;
    LSU_FAULT = 1'b0;
    LSU_STALL = 1'b0;
    case (state)
      IDLE: begin
        LSU_STALL = EX_VALID && is_mem_op;
      end
      REQ: begin
        MEM_REQ   = 1'b1;
        LSU_STALL = 1'b1;
      end
      WAIT_RESP: begin
        LSU_STALL = 1'b1;
      end
      DONE: begin
        LSU_DONE = 1'b1;
      end
      FAULT_ST: begin
        LSU_DONE  = 1'b1;
        LSU_FAULT = 1'b1;
      end
      default: begin
        LSU_STALL = 1'b0;
      end
    endcase
  end

  // Request registers are loaded once at accept and then held, which keeps
  // address/WE/strobes/data stable for the whole REQ phase.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      MEM_ADDR   <= 32'h0000_0000;
      MEM_WE     <= 1'b0;
      MEM_WSTRB  <= 4'b0000;
      MEM_WDATA  <= 32'h0000_0000;
    end else if (accept) begin
      is_store_q <= is_store_in;
      funct3_q   <= FUNCT3;
      off_q      <= ADDR[1:0];
      MEM_ADDR   <= {ADDR[31:2], 2'b00};
      MEM_WE     <= is_store_in;
      MEM_WSTRB  <= is_store_in ? store_strobe(FUNCT3, ADDR[1:0]) : 4'b0000;
      MEM_WDATA  <= store_lanes(FUNCT3, STORE_DATA);
    end
  end

  // Response timeout counter: zero outside WAIT_RESP, so it is already
  // clear on entry. It leaves WAIT_RESP before it could wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= 8'd0;
    end else if (state == WAIT_RESP) begin
      count <= count + 8'd1;
    end else begin
      count <= 8'd0;
    end
  end

  // Load result only changes on a capture edge; stores and faults leave it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_LOAD <= 32'h0000_0000;
    end else if (capture) begin
      MEM_LOAD <= load_word;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES = 4).
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_ALU   = 7'b0110011;

  logic        CLK;
  logic        RST_N;
  logic        EX_VALID;
  logic [6:0]  OPCODE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR;
  logic [31:0] STORE_DATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_WSTRB;
  logic [31:0] MEM_WDATA;
  logic        MEM_GNT;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic [31:0] MEM_LOAD;
  logic        LSU_DONE;
  logic        LSU_STALL;
  logic        LSU_FAULT;

  int assert_count;
  int fail_count;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EX_VALID   (EX_VALID),
    .OPCODE     (OPCODE),
    .FUNCT3     (FUNCT3),
    .ADDR       (ADDR),
    .STORE_DATA (STORE_DATA),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WSTRB  (MEM_WSTRB),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_GNT    (MEM_GNT),
    .MEM_RVALID (MEM_RVALID),
    .MEM_RDATA  (MEM_RDATA),
    .MEM_LOAD   (MEM_LOAD),
    .LSU_DONE   (LSU_DONE),
    .LSU_STALL  (LSU_STALL),
    .LSU_FAULT  (LSU_FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one instruction for the accept cycle, check the stall it
  // raises, then withdraw it after the accepting edge.
  task automatic applyStimulus(input string tag, input logic [6:0] op,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic exp_stall);
    EX_VALID   = 1'b1;
    OPCODE     = op;
    FUNCT3     = f3;
    ADDR       = addr;
    STORE_DATA = sdata;
    #1;
    checkOutput({tag, "_stall0"}, LSU_STALL, exp_stall);
    tick();
    EX_VALID = 1'b0;
    OPCODE   = 7'd0;
  endtask

  task automatic runLoad(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic same_cycle, input logic [31:0] exp_addr,
                         input logic [31:0] exp_load);
    applyStimulus(tag, T_LOAD, f3, addr, 32'h0, 1'b1);
    MEM_GNT = 1'b1;
    if (same_cycle) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = rdata;
    end
    #1;
    checkOutput({tag, "_req"}, MEM_REQ, 1'b1);
    checkOutput({tag, "_addr"}, MEM_ADDR, exp_addr);
    tick();
    MEM_GNT = 1'b0;
    if (!same_cycle) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = rdata;
      tick();
    end
    MEM_RVALID = 1'b0;
    #1;
    checkOutput({tag, "_done"}, LSU_DONE, 1'b1);
    checkOutput({tag, "_load"}, MEM_LOAD, exp_load);
    tick();
  endtask

  task automatic runStore(input string tag, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input int gnt_delay, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_load);
    applyStimulus(tag, T_STORE, f3, addr, sdata, 1'b1);
    for (int i = 0; i <= gnt_delay; i++) begin
      MEM_GNT = (i == gnt_delay);
      #1;
      checkOutput({tag, "_req"}, MEM_REQ, 1'b1);
      checkOutput({tag, "_we"}, MEM_WE, 1'b1);
      checkOutput({tag, "_addr"}, MEM_ADDR, exp_addr);
      checkOutput({tag, "_wstrb"}, MEM_WSTRB, exp_strb);
      checkOutput({tag, "_wdata"}, MEM_WDATA, exp_wdata);
      checkOutput({tag, "_stall"}, LSU_STALL, 1'b1);
      tick();
    end
    MEM_GNT = 1'b0;
    #1;
    checkOutput({tag, "_done"}, LSU_DONE, 1'b1);
    checkOutput({tag, "_fault"}, LSU_FAULT, 1'b0);
    checkOutput({tag, "_reqoff"}, MEM_REQ, 1'b0);
    checkOutput({tag, "_stalloff"}, LSU_STALL, 1'b0);
    checkOutput({tag, "_load"}, MEM_LOAD, exp_load);
    tick();
  endtask

  task automatic runFault(input string tag, input logic [6:0] op,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_load);
    applyStimulus(tag, op, f3, addr, 32'h1111_2222, 1'b1);
    #1;
    checkOutput({tag, "_req"}, MEM_REQ, 1'b0);
    checkOutput({tag, "_done"}, LSU_DONE, 1'b1);
    checkOutput({tag, "_fault"}, LSU_FAULT, 1'b1);
    checkOutput({tag, "_load"}, MEM_LOAD, exp_load);
    tick();
    checkOutput({tag, "_fault_end"}, LSU_FAULT, 1'b0);
    checkOutput({tag, "_req_end"}, MEM_REQ, 1'b0);
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    RST_N      = 1'b1;
    EX_VALID   = 1'b0;
    OPCODE     = 7'd0;
    FUNCT3     = 3'd0;
    ADDR       = 32'h0;
    STORE_DATA = 32'h0;
    MEM_GNT    = 1'b0;
    MEM_RVALID = 1'b0;
    MEM_RDATA  = 32'h0;
    #1;
    RST_N = 1'b0;
    repeat (2) tick();

    checkOutput("rst_req", MEM_REQ, 1'b0);
    checkOutput("rst_we", MEM_WE, 1'b0);
    checkOutput("rst_wstrb", MEM_WSTRB, 4'b0000);
    checkOutput("rst_done", LSU_DONE, 1'b0);
    checkOutput("rst_fault", LSU_FAULT, 1'b0);
    checkOutput("rst_stall", LSU_STALL, 1'b0);
    checkOutput("rst_load", MEM_LOAD, 32'h0);
    checkOutput("rst_addr", MEM_ADDR, 32'h0);
    RST_N = 1'b1;
    tick();

    // LW 0x100, grant in REQ, data one cycle later: DONE at cycle 3.
    applyStimulus("lw", T_LOAD, 3'b010, 32'h0000_0100, 32'h0, 1'b1);
    MEM_GNT = 1'b1;
    #1;
    checkOutput("lw_req1", MEM_REQ, 1'b1);
    checkOutput("lw_addr", MEM_ADDR, 32'h0000_0100);
    checkOutput("lw_wstrb", MEM_WSTRB, 4'b0000);
    checkOutput("lw_we", MEM_WE, 1'b0);
    checkOutput("lw_stall1", LSU_STALL, 1'b1);
    checkOutput("lw_done1", LSU_DONE, 1'b0);
    tick();
    MEM_GNT    = 1'b0;
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'hDEAD_BEEF;
    #1;
    checkOutput("lw_req2", MEM_REQ, 1'b0);
    checkOutput("lw_stall2", LSU_STALL, 1'b1);
    checkOutput("lw_done2", LSU_DONE, 1'b0);
    tick();
    MEM_RVALID = 1'b0;
    #1;
    checkOutput("lw_done3", LSU_DONE, 1'b1);
    checkOutput("lw_fault3", LSU_FAULT, 1'b0);
    checkOutput("lw_stall3", LSU_STALL, 1'b0);
    checkOutput("lw_load", MEM_LOAD, 32'hDEAD_BEEF);
    tick();
    checkOutput("lw_done4", LSU_DONE, 1'b0);

    // Sub-word loads, both response timings.
    runLoad("lb",  3'b000, 32'h0000_0203, 32'h80FF_7F01, 1'b0, 32'h0000_0200, 32'hFFFF_FF80);
    runLoad("lbu", 3'b100, 32'h0000_0203, 32'h80FF_7F01, 1'b1, 32'h0000_0200, 32'h0000_0080);
    runLoad("lb1", 3'b000, 32'h0000_0301, 32'h1234_7F56, 1'b1, 32'h0000_0300, 32'h0000_007F);
    runLoad("lh",  3'b001, 32'h0000_0102, 32'h8001_1234, 1'b0, 32'h0000_0100, 32'hFFFF_8001);
    runLoad("lhu", 3'b101, 32'h0000_0102, 32'h8001_1234, 1'b1, 32'h0000_0100, 32'h0000_8001);

    // Stores leave MEM_LOAD alone.
    runStore("sh", 3'b001, 32'h0000_0102, 32'h1234_ABCD, 3, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0000_8001);
    runStore("sb", 3'b000, 32'h0000_0101, 32'h0000_00A5, 0, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8001);
    runStore("sw", 3'b010, 32'h0000_010C, 32'hCAFE_F00D, 1, 32'h0000_010C, 4'b1111, 32'hCAFE_F00D, 32'h0000_8001);

    // Misaligned and illegal accesses fault without a request.
    runFault("lw_mis",  T_LOAD,  3'b010, 32'h0000_0101, 32'h0000_8001);
    runFault("ld_f3",   T_LOAD,  3'b011, 32'h0000_0100, 32'h0000_8001);
    runFault("sh_mis",  T_STORE, 3'b001, 32'h0000_0103, 32'h0000_8001);
    runFault("sbu_ill", T_STORE, 3'b100, 32'h0000_0100, 32'h0000_8001);

    // Non-memory opcode: no stall, no action.
    applyStimulus("alu", T_ALU, 3'b010, 32'h0000_0100, 32'h0, 1'b0);
    #1;
    checkOutput("alu_req", MEM_REQ, 1'b0);
    checkOutput("alu_done", LSU_DONE, 1'b0);
    checkOutput("alu_stall", LSU_STALL, 1'b0);
    tick();

    // Timeout after 4 WAIT_RESP cycles; late RVALID ignored.
    applyStimulus("to", T_LOAD, 3'b010, 32'h0000_0104, 32'h0, 1'b1);
    MEM_GNT = 1'b1;
    #1;
    checkOutput("to_req", MEM_REQ, 1'b1);
    tick();
    MEM_GNT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("to_wait_req", MEM_REQ, 1'b0);
      checkOutput("to_wait_stall", LSU_STALL, 1'b1);
      checkOutput("to_wait_done", LSU_DONE, 1'b0);
      tick();
    end
    #1;
    checkOutput("to_done", LSU_DONE, 1'b1);
    checkOutput("to_fault", LSU_FAULT, 1'b1);
    checkOutput("to_load", MEM_LOAD, 32'h0000_8001);
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'h5555_5555;
    tick();
    checkOutput("to_late_done", LSU_DONE, 1'b0);
    checkOutput("to_late_load", MEM_LOAD, 32'h0000_8001);
    tick();
    MEM_RVALID = 1'b0;
    checkOutput("to_idle_load", MEM_LOAD, 32'h0000_8001);
    checkOutput("to_idle_done", LSU_DONE, 1'b0);

    // Reset in the middle of WAIT_RESP, then a normal load.
    applyStimulus("rw", T_LOAD, 3'b010, 32'h0000_0108, 32'h0, 1'b1);
    MEM_GNT = 1'b1;
    tick();
    MEM_GNT = 1'b0;
    #1;
    checkOutput("rw_wait_stall", LSU_STALL, 1'b1);
    RST_N = 1'b0;
    #1;
    checkOutput("rw_req", MEM_REQ, 1'b0);
    checkOutput("rw_stall", LSU_STALL, 1'b0);
    checkOutput("rw_load", MEM_LOAD, 32'h0);
    checkOutput("rw_addr", MEM_ADDR, 32'h0);
    tick();
    RST_N = 1'b1;
    tick();
    runLoad("post", 3'b010, 32'h0000_010C, 32'h0BAD_F00D, 1'b0, 32'h0000_010C, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
